// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared fixed-point type, saturating adder and FSM states for psum_collector
package pe_pkg;

  localparam int TOP_BITS = 2;
  localparam int BOT_BITS = 14;
  localparam int PSUM_W   = TOP_BITS + BOT_BITS;
  localparam int SAT_W    = 32;

  typedef logic signed [PSUM_W-1:0] psum_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  // Operands arrive sign-extended from a w-bit format; result is clamped to that format.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W:0] w_sum;
    logic signed [SAT_W:0] w_max;
    logic signed [SAT_W:0] w_min;
    logic signed [SAT_W:0] w_one;
    w_one = (SAT_W+1)'(1);
    w_sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    w_max = (w_one <<< (w - 1)) - w_one;
    w_min = -(w_one <<< (w - 1));
    if (w_sum > w_max) begin
      return SAT_W'(w_max);
    end else if (w_sum < w_min) begin
      return SAT_W'(w_min);
    end
    return SAT_W'(w_sum);
  endfunction

endpackage

// File: rtl/psum_lane.sv
// rtl/psum_lane.sv - one psum lane: accumulator buffer, write pointer, pass counter, saturating adder
module psum_lane
  import pe_pkg::*;
#(
  parameter int G_W           = 16,
  parameter int G_OFMAP_WIDTH = 24,
  parameter int G_PASS_WIDTH  = 4,
  parameter int G_IDX_W       = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    vld_i,
  input  logic [G_W-1:0]          psum_i,
  input  logic [G_PASS_WIDTH-1:0] num_pass_i,
  input  logic [G_IDX_W-1:0]      rd_idx_i,
  output logic [G_W-1:0]          rd_data_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam logic [G_IDX_W-1:0] IDX_LAST = G_IDX_W'(G_OFMAP_WIDTH - 1);

  logic [G_W-1:0]          r_buf [G_OFMAP_WIDTH];
  logic [G_IDX_W-1:0]      r_ptr;
  logic [G_PASS_WIDTH-1:0] r_pass;

  logic           w_wr;
  logic [G_W-1:0] w_entry;
  logic [G_W-1:0] w_wdata;

  assign done_o  = (r_pass == num_pass_i);
  assign w_wr    = en_i & vld_i & ~done_o;
  assign err_o   = en_i & vld_i & done_o;
  assign w_entry = r_buf[r_ptr];

  // First pass overwrites whatever a previous job left behind.
  assign w_wdata = (r_pass == '0) ? psum_i
                 : G_W'(sat_add(SAT_W'(signed'(w_entry)), SAT_W'(signed'(psum_i)), G_W));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr  <= '0;
      r_pass <= '0;
    end else if (clr_i) begin
      r_ptr  <= '0;
      r_pass <= '0;
    end else if (w_wr) begin
      if (r_ptr == IDX_LAST) begin
        r_ptr  <= '0;
        r_pass <= r_pass + 1'b1;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_buf[r_ptr] <= w_wdata;
    end
  end

  assign rd_data_o = r_buf[rd_idx_i];

endmodule

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - multi-pass psum accumulator with lane-major drain; PSUM_COLLECTOR_RELU_EN clamps negative outputs to 0
module psum_collector
  import pe_pkg::*;
#(
  parameter int G_ARRAY_WIDTH = 4,
  parameter int G_TOP_BITS    = TOP_BITS,
  parameter int G_BOT_BITS    = BOT_BITS,
  parameter int G_OFMAP_WIDTH = 24,
  parameter int G_PASS_WIDTH  = 4,
  localparam int W     = G_TOP_BITS + G_BOT_BITS,
  localparam int COL_W = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1,
  localparam int IDX_W = (G_OFMAP_WIDTH > 1) ? $clog2(G_OFMAP_WIDTH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [G_PASS_WIDTH-1:0]    num_pass_i,
  input  logic [G_ARRAY_WIDTH-1:0]   psum_vld_i,
  input  logic [G_ARRAY_WIDTH*W-1:0] psum_i,
  output logic                       out_vld_o,
  input  logic                       out_rdy_i,
  output logic [W-1:0]               out_data_o,
  output logic [COL_W-1:0]           out_col_o,
  output logic [IDX_W-1:0]           out_idx_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(G_ARRAY_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(G_OFMAP_WIDTH - 1);

  state_t                  r_state;
  logic [G_PASS_WIDTH-1:0] r_num;
  logic [COL_W-1:0]        r_rd_col;
  logic [IDX_W-1:0]        r_rd_idx;
  logic                    r_out_vld;
  logic [W-1:0]            r_out_data;
  logic [COL_W-1:0]        r_out_col;
  logic [IDX_W-1:0]        r_out_idx;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic [W-1:0]             w_rd_data [G_ARRAY_WIDTH];
  logic [G_ARRAY_WIDTH-1:0] w_lane_done;
  logic [G_ARRAY_WIDTH-1:0] w_lane_err;
  logic                     w_start;
  logic                     w_accum;
  logic                     w_xfer;
  logic                     w_out_last;
  logic [W-1:0]             w_rd_sel;
  logic [W-1:0]             w_rd_out;

  assign w_start    = start_i && (r_state == IDLE);
  assign w_accum    = (r_state == ACCUM);
  assign w_xfer     = r_out_vld && out_rdy_i;
  assign w_out_last = (r_out_col == COL_LAST) && (r_out_idx == IDX_LAST);

  for (genvar g = 0; g < G_ARRAY_WIDTH; g++) begin : g_lane
    psum_lane #(
      .G_W          (W),
      .G_OFMAP_WIDTH(G_OFMAP_WIDTH),
      .G_PASS_WIDTH (G_PASS_WIDTH),
      .G_IDX_W      (IDX_W)
    ) u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (w_start),
      .en_i      (w_accum),
      .vld_i     (psum_vld_i[g]),
      .psum_i    (psum_i[g*W +: W]),
      .num_pass_i(r_num),
      .rd_idx_i  (r_rd_idx),
      .rd_data_o (w_rd_data[g]),
      .done_o    (w_lane_done[g]),
      .err_o     (w_lane_err[g])
    );
  end

  assign w_rd_sel = w_rd_data[r_rd_col];

`ifdef PSUM_COLLECTOR_RELU_EN
  assign w_rd_out = w_rd_sel[W-1] ? '0 : w_rd_sel;
`else
  assign w_rd_out = w_rd_sel;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_num      <= '0;
      r_rd_col   <= '0;
      r_rd_idx   <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_col  <= '0;
      r_out_idx  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state  <= ACCUM;
            r_busy   <= 1'b1;
            r_num    <= (num_pass_i == '0) ? G_PASS_WIDTH'(1) : num_pass_i;
            r_err    <= 1'b0;
            r_rd_col <= '0;
            r_rd_idx <= '0;
          end else if (|psum_vld_i) begin
            r_err <= 1'b1;
          end
        end
        ACCUM: begin
          if (|w_lane_err) r_err <= 1'b1;
          if (&w_lane_done) r_state <= DRAIN;
        end
        DRAIN: begin
          if (|psum_vld_i) r_err <= 1'b1;
          // Output register refills on the first DRAIN cycle and after every accepted beat.
          if (!r_out_vld || w_xfer) begin
            if (r_out_vld && w_out_last) begin
              r_out_vld <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_out_vld  <= 1'b1;
              r_out_data <= w_rd_out;
              r_out_col  <= r_rd_col;
              r_out_idx  <= r_rd_idx;
              if (r_rd_idx == IDX_LAST) begin
                r_rd_idx <= '0;
                r_rd_col <= r_rd_col + 1'b1;
              end else begin
                r_rd_idx <= r_rd_idx + 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (|psum_vld_i) r_err <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_vld_o  = r_out_vld;
  assign out_data_o = r_out_data;
  assign out_col_o  = r_out_col;
  assign out_idx_o  = r_out_idx;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - table-driven directed bench for psum_collector
module tb_psum_collector;

  localparam int AW = 4;
  localparam int W  = 16;
  localparam int OW = 24;
  localparam int PW = 4;

  typedef struct {
    int npass;
    int base;
    int sidx;
    int scol;
    int ebase;
    int esidx;
    int escol;
    int rdy_pct;
    bit skew;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] num_pass = '0;
  logic [AW-1:0] vld = '0;
  logic [AW*W-1:0] psum = '0;
  logic          out_rdy = 1'b0;
  logic          out_vld;
  logic [W-1:0]  out_data;
  logic [1:0]    out_col;
  logic [4:0]    out_idx;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs[6];

  psum_collector dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .num_pass_i(num_pass),
    .psum_vld_i(vld),
    .psum_i    (psum),
    .out_vld_o (out_vld),
    .out_rdy_i (out_rdy),
    .out_data_o(out_data),
    .out_col_o (out_col),
    .out_idx_o (out_idx),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic draw_rdy(input int pct);
    if (pct >= 100) return 1'b1;
    return ($urandom_range(99) < pct);
  endfunction

  task automatic collect(input vec_t v, input bit start_in_drain);
    int n, k, first, dones, c_exp, i_exp;
    bit stalled, pulsed;
    logic [W-1:0] hd, exp;
    logic [1:0] hc;
    logic [4:0] hi;
    n = 0; k = 0; first = -1; dones = 0; stalled = 0; pulsed = 0;
    hd = '0; hc = '0; hi = '0;
    while (k < 6000 && !(n >= AW*OW && dones > 0 && !busy)) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (out_vld && first < 0) first = k;
      if (stalled) begin
        chk("stall_vld", out_vld, 1);
        chk("stall_data", out_data, hd);
        chk("stall_col", out_col, hc);
        chk("stall_idx", out_idx, hi);
      end
      stalled = 0;
      out_rdy = draw_rdy(v.rdy_pct);
      if (out_vld && out_rdy) begin
        c_exp = n / OW;
        i_exp = n % OW;
        exp = W'(v.ebase + v.esidx*i_exp + v.escol*c_exp);
`ifdef PSUM_COLLECTOR_RELU_EN
        if (exp[W-1]) exp = '0;
`endif
        chk($sformatf("out_data n=%0d", n), out_data, exp);
        chk($sformatf("out_col n=%0d", n), out_col, c_exp);
        chk($sformatf("out_idx n=%0d", n), out_idx, i_exp);
        n++;
      end else if (out_vld) begin
        stalled = 1;
        hd = out_data; hc = out_col; hi = out_idx;
      end
      if (done) dones++;
      if (start_in_drain && !pulsed && n == 5) begin
        start = 1'b1;
        num_pass = 4'd3;
        pulsed = 1;
      end
    end
    out_rdy = 1'b0;
    chk("drain_in_bound", k < 6000, 1);
    chk("xfer_count", n, AW*OW);
    chk("done_pulses", dones, 1);
    chk("first_vld_latency", first, 2);
    chk("busy_after_done", busy, 0);
    chk("vld_after_done", out_vld, 0);
  endtask

  task automatic run_job(input vec_t v);
    int sent[AW];
    int total, cyc, nd;
    @(negedge clk);
    num_pass = PW'(v.npass);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err, 0);
    total = ((v.npass == 0) ? 1 : v.npass) * OW;
    for (int c = 0; c < AW; c++) sent[c] = 0;
    cyc = 0;
    while (cyc < 4000) begin
      for (int c = 0; c < AW; c++) begin
        if (sent[c] < total && (!v.skew || ((cyc + c) % (c + 2)) != 0)) begin
          vld[c] = 1'b1;
          psum[c*W +: W] = W'(v.base + v.sidx*(sent[c] % OW) + v.scol*c);
          sent[c]++;
        end else begin
          vld[c] = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
      nd = 0;
      for (int c = 0; c < AW; c++) if (sent[c] == total) nd++;
      if (nd == AW) break;
    end
    vld = '0;
    psum = '0;
    chk("feed_in_bound", cyc < 4000, 1);
    collect(v, 0);
    chk("err_clean", err, 0);
  endtask

  task automatic err_seq();
    @(negedge clk);
    num_pass = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < OW; i++) begin
      vld = 4'b0111;
      for (int c = 0; c < 3; c++) psum[c*W +: W] = W'('h0100*(i+1));
      @(negedge clk);
    end
    vld = 4'b0001;
    psum[0 +: W] = 16'h7777;
    @(negedge clk);
    vld = '0;
    chk("err_after_extra", err, 1);
    chk("busy_in_accum", busy, 1);
    for (int i = 0; i < OW; i++) begin
      vld = 4'b1000;
      psum[3*W +: W] = W'('h0100*(i+1));
      @(negedge clk);
    end
    vld = '0;
    psum = '0;
    collect(vecs[0], 1);
    chk("err_sticky", err, 1);
  endtask

  task automatic reset_seq();
    @(negedge clk);
    num_pass = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < OW; i++) begin
      vld = (i < 10) ? 4'b1111 : 4'b0001;
      for (int c = 0; c < AW; c++) psum[c*W +: W] = W'('h0100*(i+1));
      @(negedge clk);
    end
    vld = 4'b0001;
    @(negedge clk);
    vld = '0;
    chk("err_before_reset", err, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_vld", out_vld, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vld = 4'b0100;
    @(negedge clk);
    vld = '0;
    chk("err_idle_vld", err, 1);
    chk("idle_vld_busy", busy, 0);
    run_job(vecs[0]);
  endtask

  initial begin
    vecs[0] = '{1, 'h0100, 'h0100, 0,      'h0100, 'h0100, 0,      100, 1'b0};
    vecs[1] = '{3, 'h1000, 0,      0,      'h3000, 0,      0,      100, 1'b0};
    vecs[2] = '{2, 'h7000, 0,      0,      'h7FFF, 0,      0,      100, 1'b0};
    vecs[3] = '{2, 'h9000, 0,      0,      'h8000, 0,      0,      100, 1'b0};
    vecs[4] = '{0, 'h0010, 1,      'h0200, 'h0010, 1,      'h0200, 30,  1'b1};
    vecs[5] = '{2, 'hF000, 1,      'h0100, 'hE000, 2,      'h0200, 100, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    for (int r = 0; r < 6; r++) run_job(vecs[r]);
    err_seq();
    reset_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
